// File: rtl/dfi_datapath_ctl.sv
// Fabric-side DFI data-path controller: delays per-phase read/write enables by
// run-time latencies into read-valid, DQ/DQS drive and postamble strobes.
module dfi_datapath_ctl #(
  parameter int unsigned NPHASES   = 2,
  parameter int unsigned MAX_RDLAT = 15,
  parameter int unsigned MAX_WRLAT = 7,
  parameter int unsigned RLW       = $clog2(MAX_RDLAT + 1),
  parameter int unsigned WLW       = $clog2(MAX_WRLAT + 1)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [RLW-1:0]     rdlat,
  input  logic [WLW-1:0]     wrlat,
  input  logic [NPHASES-1:0] dfi_rddata_en_p,
  input  logic [NPHASES-1:0] dfi_wrdata_en_p,
  input  logic               clr_err,
  output logic [NPHASES-1:0] dfi_rddata_valid_w,
  output logic [NPHASES-1:0] drive_dq,
  output logic               drive_dqs,
  output logic               dqs_postamble,
  output logic               busy,
  output logic               collision
);

  // Stage k holds an enable k+1 cycles old; the output register adds the last cycle.
  localparam int unsigned RD_DEPTH = (MAX_RDLAT > 1) ? MAX_RDLAT - 1 : 1;
  localparam int unsigned WR_DEPTH = (MAX_WRLAT > 1) ? MAX_WRLAT - 1 : 1;

  logic [RLW-1:0]     rdlat_eff;
  logic [WLW-1:0]     wrlat_eff;
  logic [NPHASES-1:0] rd_sr [RD_DEPTH];
  logic [NPHASES-1:0] wr_sr [WR_DEPTH];
  logic [NPHASES-1:0] rd_tap_c;
  logic [NPHASES-1:0] wr_tap_c;
  logic               rd_pend_c;
  logic               wr_pend_c;
  logic               post_next_c;
  logic               busy_next_c;
  logic               lat_load_c;

  function automatic logic [RLW-1:0] clamp_rd(input logic [RLW-1:0] v);
    if (v == '0)                          clamp_rd = RLW'(1);
    else if (int'(v) > int'(MAX_RDLAT))   clamp_rd = RLW'(MAX_RDLAT);
    else                                  clamp_rd = v;
  endfunction

  function automatic logic [WLW-1:0] clamp_wr(input logic [WLW-1:0] v);
    if (v == '0)                          clamp_wr = WLW'(1);
    else if (int'(v) > int'(MAX_WRLAT))   clamp_wr = WLW'(MAX_WRLAT);
    else                                  clamp_wr = v;
  endfunction

  // Latencies only move while nothing is in flight, so every enable sees a stable tap.
  assign lat_load_c = sys_rst | (~busy & ~(|dfi_rddata_en_p) & ~(|dfi_wrdata_en_p));

  always_ff @(posedge sys_clk) begin
    if (lat_load_c) begin
      rdlat_eff <= clamp_rd(rdlat);
      wrlat_eff <= clamp_wr(wrlat);
    end
  end

  // Tap selection and in-flight detection
  always_comb begin
    rd_tap_c  = '0;
    rd_pend_c = 1'b0;
    if (rdlat_eff == RLW'(1)) rd_tap_c = dfi_rddata_en_p;
    for (int k = 0; k < int'(RD_DEPTH); k++) begin
      if (k + 2 == int'(rdlat_eff)) rd_tap_c = rd_sr[k];
      rd_pend_c = rd_pend_c | (|rd_sr[k]);
    end
  end

  always_comb begin
    wr_tap_c  = '0;
    wr_pend_c = 1'b0;
    if (wrlat_eff == WLW'(1)) wr_tap_c = dfi_wrdata_en_p;
    for (int k = 0; k < int'(WR_DEPTH); k++) begin
      if (k + 2 == int'(wrlat_eff)) wr_tap_c = wr_sr[k];
      wr_pend_c = wr_pend_c | (|wr_sr[k]);
    end
  end

  assign post_next_c = (|drive_dq) & ~(|wr_tap_c);
  assign busy_next_c = (|dfi_rddata_en_p) | (|dfi_wrdata_en_p) | rd_pend_c | wr_pend_c | post_next_c;

  // Stages past the active tap are held at zero so a later latency increase
  // cannot pick up stale bits.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int k = 0; k < int'(RD_DEPTH); k++) rd_sr[k] <= '0;
    end else begin
      rd_sr[0] <= (int'(rdlat_eff) >= 2) ? dfi_rddata_en_p : '0;
      for (int k = 1; k < int'(RD_DEPTH); k++)
        rd_sr[k] <= (k + 2 <= int'(rdlat_eff)) ? rd_sr[k-1] : '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int k = 0; k < int'(WR_DEPTH); k++) wr_sr[k] <= '0;
    end else begin
      wr_sr[0] <= (int'(wrlat_eff) >= 2) ? dfi_wrdata_en_p : '0;
      for (int k = 1; k < int'(WR_DEPTH); k++)
        wr_sr[k] <= (k + 2 <= int'(wrlat_eff)) ? wr_sr[k-1] : '0;
    end
  end

  // Output registers; collision set beats clear
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dfi_rddata_valid_w <= '0;
      drive_dq           <= '0;
      drive_dqs          <= 1'b0;
      dqs_postamble      <= 1'b0;
      busy               <= 1'b0;
      collision          <= 1'b0;
    end else begin
      dfi_rddata_valid_w <= rd_tap_c;
      drive_dq           <= wr_tap_c;
      drive_dqs          <= |wr_tap_c;
      dqs_postamble      <= post_next_c;
      busy               <= busy_next_c;
      collision          <= ((|dfi_rddata_valid_w) & (|drive_dq)) | (collision & ~clr_err);
    end
  end

endmodule

// File: tb/tb_dfi_datapath_ctl.sv
// Directed bench for dfi_datapath_ctl: per-cycle stimulus and hand-derived
// expected outputs over a fixed timeline.
module tb_dfi_datapath_ctl;

  localparam int unsigned NPHASES   = 2;
  localparam int unsigned MAX_RDLAT = 12;
  localparam int unsigned MAX_WRLAT = 7;
  localparam int unsigned RLW       = $clog2(MAX_RDLAT + 1);
  localparam int unsigned WLW       = $clog2(MAX_WRLAT + 1);
  localparam int          LAST_CYC  = 97;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic [RLW-1:0]     rdlat;
  logic [WLW-1:0]     wrlat;
  logic [NPHASES-1:0] dfi_rddata_en_p;
  logic [NPHASES-1:0] dfi_wrdata_en_p;
  logic               clr_err;
  logic [NPHASES-1:0] dfi_rddata_valid_w;
  logic [NPHASES-1:0] drive_dq;
  logic               drive_dqs;
  logic               dqs_postamble;
  logic               busy;
  logic               collision;

  int n_checks = 0;
  int n_pass   = 0;

  dfi_datapath_ctl #(
    .NPHASES(NPHASES), .MAX_RDLAT(MAX_RDLAT), .MAX_WRLAT(MAX_WRLAT), .RLW(RLW), .WLW(WLW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rdlat(rdlat), .wrlat(wrlat),
    .dfi_rddata_en_p(dfi_rddata_en_p), .dfi_wrdata_en_p(dfi_wrdata_en_p), .clr_err(clr_err),
    .dfi_rddata_valid_w(dfi_rddata_valid_w), .drive_dq(drive_dq), .drive_dqs(drive_dqs),
    .dqs_postamble(dqs_postamble), .busy(busy), .collision(collision)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs presented during cycle c
  task automatic apply_inputs(input int c);
    sys_rst         = (c == 0 || c == 1 || c == 46);
    clr_err         = (c == 38);
    if (c < 11)       rdlat = RLW'(5);
    else if (c < 24)  rdlat = RLW'(3);
    else if (c < 36)  rdlat = RLW'(4);
    else if (c < 50)  rdlat = RLW'(5);
    else if (c < 62)  rdlat = RLW'(0);
    else              rdlat = RLW'(15);
    if (c < 50)       wrlat = WLW'(1);
    else if (c < 80)  wrlat = WLW'(0);
    else              wrlat = WLW'(7);
    case (c)
      10, 30, 55: dfi_rddata_en_p = 2'b01;
      20, 65:     dfi_rddata_en_p = 2'b10;
      44:         dfi_rddata_en_p = 2'b11;
      default:    dfi_rddata_en_p = 2'b00;
    endcase
    case (c)
      20, 21:     dfi_wrdata_en_p = 2'b11;
      33, 85:     dfi_wrdata_en_p = 2'b01;
      58:         dfi_wrdata_en_p = 2'b10;
      default:    dfi_wrdata_en_p = 2'b00;
    endcase
  endtask

  task automatic check_cycle(input int c);
    logic [1:0] e_valid, e_drive;
    logic       e_post, e_busy, e_coll;
    case (c)
      15, 34, 56: e_valid = 2'b01;
      23, 77:     e_valid = 2'b10;
      default:    e_valid = 2'b00;
    endcase
    case (c)
      21, 22:     e_drive = 2'b11;
      34, 92:     e_drive = 2'b01;
      59:         e_drive = 2'b10;
      default:    e_drive = 2'b00;
    endcase
    e_post = (c == 23 || c == 35 || c == 60 || c == 93);
    e_busy = (c >= 11 && c <= 15) || (c >= 21 && c <= 23) || (c >= 31 && c <= 35) ||
             (c == 45 || c == 46) || (c == 56) || (c == 59 || c == 60) ||
             (c >= 66 && c <= 77) || (c >= 86 && c <= 93);
    e_coll = (c >= 35 && c <= 38);
    check_eq($sformatf("c%0d valid", c),     8'(dfi_rddata_valid_w), 8'(e_valid));
    check_eq($sformatf("c%0d drive_dq", c),  8'(drive_dq),           8'(e_drive));
    check_eq($sformatf("c%0d drive_dqs", c), 8'(drive_dqs),          8'(|e_drive));
    check_eq($sformatf("c%0d postamble", c), 8'(dqs_postamble),      8'(e_post));
    check_eq($sformatf("c%0d busy", c),      8'(busy),               8'(e_busy));
    check_eq($sformatf("c%0d collision", c), 8'(collision),          8'(e_coll));
  endtask

  initial begin
    apply_inputs(0);
    for (int c = 1; c <= LAST_CYC; c++) begin
      @(posedge sys_clk);
      #1;
      check_cycle(c);
      apply_inputs(c);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
